// File: rtl/apa102_axis_shifter.sv
// AXI-Stream to APA102 serial shifter: each accepted 32-bit word is sent MSB-first
// as SPI mode 0, with an optional all-ones end frame appended when tlast is set.
module apa102_axis_shifter #(
  parameter int CLK_DIV  = 120,
  parameter int END_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        o_led_clk,
  output logic        o_led_data,
  output logic        o_busy
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITS_MAX = ((END_BITS - 1) > 31) ? (END_BITS - 1) : 31;
  localparam int BIT_W    = $clog2(BITS_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] WORD_LAST  = BIT_W'(31);
  localparam logic [BIT_W-1:0] END_LAST   = BIT_W'(END_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_shift;
  logic [BIT_W-1:0] r_bitcnt;
  logic [DIV_W-1:0] r_divcnt;
  logic             r_endpend;
  logic             r_led_clk;
  logic             r_led_data;

  state_t           w_state_nxt;
  logic [31:0]      w_shift_nxt;
  logic [BIT_W-1:0] w_bitcnt_nxt;
  logic [DIV_W-1:0] w_divcnt_nxt;
  logic             w_endpend_nxt;
  logic             w_led_clk_nxt;
  logic             w_led_data_nxt;
  logic             w_div_done;

  assign w_div_done    = (r_divcnt == '0);
  assign s_axis_tready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_led_clk     = r_led_clk;
  assign o_led_data    = r_led_data;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_divcnt   <= '0;
      r_endpend  <= 1'b0;
      r_led_clk  <= 1'b0;
      r_led_data <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_divcnt   <= w_divcnt_nxt;
      r_endpend  <= w_endpend_nxt;
      r_led_clk  <= w_led_clk_nxt;
      r_led_data <= w_led_data_nxt;
    end
  end

  // Ones are shifted in at the bottom: ordinary words never expose them, and an
  // end frame longer than 32 bits keeps reading ones.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bitcnt_nxt   = r_bitcnt;
    w_divcnt_nxt   = r_divcnt;
    w_endpend_nxt  = r_endpend;
    w_led_clk_nxt  = r_led_clk;
    w_led_data_nxt = r_led_data;
    case (r_state)
      ST_IDLE: begin
        w_led_clk_nxt = 1'b0;
        if (s_axis_tvalid) begin
          w_shift_nxt    = s_axis_data;
          w_led_data_nxt = s_axis_data[31];
          w_bitcnt_nxt   = WORD_LAST;
          w_divcnt_nxt   = DIV_RELOAD;
          w_endpend_nxt  = s_axis_tlast;
          w_state_nxt    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_div_done) begin
          w_state_nxt   = ST_HIGH;
          w_led_clk_nxt = 1'b1;
          w_divcnt_nxt  = DIV_RELOAD;
        end else begin
          w_divcnt_nxt = r_divcnt - DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (w_div_done) begin
          w_led_clk_nxt = 1'b0;
          w_divcnt_nxt  = DIV_RELOAD;
          if (r_bitcnt != '0) begin
            w_shift_nxt    = {r_shift[30:0], 1'b1};
            w_led_data_nxt = r_shift[30];
            w_bitcnt_nxt   = r_bitcnt - BIT_W'(1);
            w_state_nxt    = ST_LOW;
          end else if (r_endpend) begin
            // End frame follows the last data bit with no idle gap.
            w_endpend_nxt  = 1'b0;
            w_shift_nxt    = '1;
            w_bitcnt_nxt   = END_LAST;
            w_led_data_nxt = 1'b1;
            w_state_nxt    = ST_LOW;
          end else begin
            w_led_data_nxt = 1'b0;
            w_state_nxt    = ST_IDLE;
          end
        end else begin
          w_divcnt_nxt = r_divcnt - DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_led_clk_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/apa102_axis_shifter.md
Name: apa102_axis_shifter

Overview:
- Downstream serializer for the Blinkt LED bar controller.
- Accepts 32-bit APA102 words (start frame, LED frames, end frame) over an AXI-Stream slave.
- Shifts each word MSB-first onto o_led_clk/o_led_data (SPI mode 0; the LED samples on the rising edge).
- Optionally appends an all-ones end frame when tlast is set, so upstream can close a strip update without pushing a separate word.

Parameters:
- CLK_DIV, 120, i_clk cycles per SCK half-period; minimum 1.
- END_BITS, 32, number of '1' bits appended after a word accepted with tlast; minimum 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- s_axis_data  in  32  word to shift; bit 31 is sent first.
- s_axis_tvalid  in  1  upstream word valid.
- s_axis_tlast  in  1  append END_BITS ones after this word; tie 0 if unused.
- s_axis_tready  out  1  block can accept a word.
- o_led_clk  out  1  serial clock to LED strip.
- o_led_data  out  1  serial data to LED strip.
- o_busy  out  1  shifting in progress.

Interface decision: one clock (i_clk); reset i_rst is asynchronous and active-low.

Behaviour:
- Reset (async, i_rst=0):
  - state=IDLE, o_led_clk=0, o_led_data=0, o_busy=0, end-pending flag=0, counters=0.
  - s_axis_tready=1, since it is decoded from state==IDLE.
  - Reset mid-word aborts the word immediately; no partial completion after release.
- States: IDLE, LOW, HIGH.
- s_axis_tready = (state==IDLE), combinational from registered state.
- o_busy = (state!=IDLE), registered-equivalent.
- Handshake occurs at a rising edge where tvalid & tready. At that edge:
  - shift<=data, o_led_data<=data[31], bitcnt<=31, divcnt<=CLK_DIV-1.
  - endpend<=tlast, state<=LOW.
  - Data bit is therefore valid the cycle after the handshake.
- LOW: o_led_clk=0. When divcnt==0: state<=HIGH, o_led_clk<=1, divcnt<=CLK_DIV-1; else divcnt decrements.
- HIGH: o_led_clk=1. When divcnt==0:
  - o_led_clk<=0, divcnt<=CLK_DIV-1.
  - If bitcnt!=0: shift<<=1, o_led_data<=next bit, bitcnt-1, state<=LOW.
  - Else if endpend: endpend<=0, shift<=all ones, bitcnt<=END_BITS-1, o_led_data<=1, state<=LOW. No gap cycle before the end frame.
  - Else: state<=IDLE, o_led_data<=0.
- Timing:
  - Each bit is exactly 2*CLK_DIV cycles: CLK_DIV low, then CLK_DIV high.
  - o_led_data changes only on the low-going edge or at the load, never while o_led_clk=1.
  - A word occupies 64*CLK_DIV cycles. tready re-asserts in the cycle after the final HIGH phase ends.
  - Back-to-back throughput is one word per 64*CLK_DIV+1 cycles (one IDLE cycle between words).
- tvalid without tready: data, tlast and tvalid are not sampled; changes while busy have no effect.
- tlast=0 words never generate extra bits. The end frame counts toward busy, and tready stays 0 throughout it.
- Counter widths:
  - divcnt: $clog2(CLK_DIV) bits, minimum 1.
  - bitcnt: enough bits for max(31, END_BITS-1).
  - No wrap-around is possible, since the counters reload before underflow.

Test Plan:
1. Reset (CLK_DIV=2): hold i_rst=0 for 5 cycles -> tready=1, o_led_clk=0, o_led_data=0, o_busy=0; release, no tvalid -> outputs static for 100 cycles.
2. Single word (CLK_DIV=2): 0xE0FF0000, tlast=0 ->
   - 32 rising o_led_clk edges; bits sampled at rising edges rebuild 0xE0FF0000.
   - Clock high 2 / low 2 cycles.
   - tready=0 for 128 cycles after the accepting edge, then 1; o_led_data=0 afterwards.
3. Back-to-back (CLK_DIV=2): 0x12345678 then 0x9ABCDEF0, tvalid held high ->
   - 64 rising edges reconstructing both words in order.
   - Exactly one cycle with tready=1 between words; o_led_clk low 3 consecutive cycles at the boundary.
4. End frame (CLK_DIV=1, END_BITS=32): 0xFF0000FF with tlast=1 ->
   - 64 rising edges: 0xFF0000FF followed by 32 ones.
   - o_busy high continuously for 128 cycles; tready never high during that time.
5. Stalled upstream: while busy, change s_axis_data every cycle with tvalid=1 -> only the value present at the handshake edge is shifted; the next word is accepted on the first tready cycle.
6. Reset mid-word (CLK_DIV=2): drop i_rst during bit 10 of 0xAAAAAAAA -> outputs go 0 asynchronously. After release, sending 0x80000001 produces exactly 32 bits starting with 1, and no residue from the aborted word.
